// File: rtl/tetris_pkg.sv
// Shared piece encoding and queue state definitions for the piece queue
// and its storage sub-module.
package tetris_pkg;

    localparam int PIECE_W = 2;

    typedef logic [PIECE_W-1:0] piece_t;

    localparam piece_t PIECE_NONE = 2'd0;
    localparam piece_t PIECE_T1   = 2'd1;
    localparam piece_t PIECE_T2   = 2'd2;
    localparam piece_t PIECE_T3   = 2'd3;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/piece_queue_if.sv
// Handshake bundle between the game logic (master) and the piece queue
// (slave): random feed, spawn request/ack and the queue status outputs.
interface piece_queue_if
    import tetris_pkg::*;
#(
    parameter int DEPTH = 3
) ();

    piece_t                        random;
    logic                          spawn_req;
    logic                          piece_valid;
    piece_t                        piece_type;
    piece_t                        next_type;
    logic                          spawn_ack;
    piece_t                        spawned_type;
    logic [$clog2(DEPTH+1)-1:0]    count;

    modport master (
        output random, spawn_req,
        input  piece_valid, piece_type, next_type, spawn_ack, spawned_type, count
    );

    modport slave (
        input  random, spawn_req,
        output piece_valid, piece_type, next_type, spawn_ack, spawned_type, count
    );

endinterface

// File: rtl/piece_fifo.sv
// Circular buffer of DEPTH piece entries with head/tail pointers and an
// occupancy count; exposes head, second and tail entries combinationally.
module piece_fifo
    import tetris_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  piece_t                     wdata,
    output piece_t                     head,
    output piece_t                     second,
    output piece_t                     tail,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef logic [PW-1:0] ptr_t;

    piece_t mem [DEPTH];
    ptr_t   rd_ptr;
    ptr_t   wr_ptr;
    logic   pop_ok;
    logic   push_ok;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH-1)) ? '0 : p + ptr_t'(1);
    endfunction

    function automatic ptr_t ptr_dec(ptr_t p);
        return (p == '0) ? ptr_t'(DEPTH-1) : p - ptr_t'(1);
    endfunction

    // Guards keep the count inside 0..DEPTH even if the caller misbehaves.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

    assign head   = mem[rd_ptr];
    assign second = mem[ptr_inc(rd_ptr)];
    assign tail   = mem[ptr_dec(wr_ptr)];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: the entries are reset too, because the reset state is
            // defined as all-zero rather than "don't care".
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PIECE_NONE;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/piece_queue.sv
// Upcoming-piece queue: fills from the random feed with anti-repeat, then
// serves spawn requests with a one-cycle ack, at most one pop per two cycles.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    piece_queue_if.slave  bus
);

    localparam int CW = $clog2(DEPTH+1);

    state_t          state;
    piece_t          head;
    piece_t          second;
    piece_t          tail;
    piece_t          spawned_q;
    logic [CW-1:0]   count;
    logic            ack_q;
    logic            run;
    logic            full;
    logic            pop;
    logic            pushable;
    logic            push;

    assign run  = (state == RUN);
    assign full = (count == CW'(DEPTH));

    // The ack cycle blocks a second acceptance of a still-held request.
    assign pop = run && (count != '0) && bus.spawn_req && !ack_q;

    // Anti-repeat compares against the current tail, even when it is being popped.
    assign pushable = (bus.random != PIECE_NONE) &&
                      ((count == '0) || (bus.random != tail));
    assign push     = pushable && (!full || pop);

    piece_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .wdata  (bus.random),
        .head   (head),
        .second (second),
        .tail   (tail),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            ack_q     <= 1'b0;
            spawned_q <= PIECE_NONE;
        end else begin
            ack_q <= pop;
            if (pop) begin
                spawned_q <= head;
            end
            if ((state == FILL) && push && (count == CW'(DEPTH-1))) begin
                state <= RUN;
            end
        end
    end

    assign bus.piece_valid  = run && (count != '0);
    assign bus.piece_type   = bus.piece_valid ? head : PIECE_NONE;
    assign bus.next_type    = (run && (count >= CW'(2))) ? second : PIECE_NONE;
    assign bus.spawn_ack    = ack_q;
    assign bus.spawned_type = spawned_q;
    assign bus.count        = count;

endmodule
